// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: shared mode encodings and FSM state
// type for the sequential shift register slice.
package shiftreg_pkg;

   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_LSL = 2'b01;
   localparam logic [1:0] MODE_ASR = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational single-bit step.
// value/mode/ser_in in; nxt (stepped value), out_bit out.
module shift_step
#(
   parameter int WIDTH = 8
)
(
   input  logic [WIDTH-1:0] value,
   input  logic [1:0]       mode,
   input  logic             ser_in,
   output logic [WIDTH-1:0] nxt,
   output logic             out_bit
);
   import shiftreg_pkg::*;

   always_comb begin
      nxt     = value;
      out_bit = 1'b0;
      unique case (1'b1)
         (mode == MODE_LSR): begin
            nxt     = {ser_in, value[WIDTH-1:1]};
            out_bit = value[0];
         end
         (mode == MODE_LSL): begin
            nxt     = {value[WIDTH-2:0], ser_in};
            out_bit = value[WIDTH-1];
         end
         (mode == MODE_ASR): begin
            nxt     = {value[WIDTH-1],
                       value[WIDTH-1:1]};
            out_bit = value[0];
         end
         (mode == MODE_ROR): begin
            nxt     = {value[0], value[WIDTH-1:1]};
            out_bit = value[0];
         end
         default: begin
            nxt     = value;
            out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shiftreg_seq.sv
// shiftreg_seq: loadable register doing N-step shifts/rotates.
// Ports: clk, reset(n), load/in_data, start/amount/mode, ser_in,
// abort -> out_q, ser_out, busy, done, zero.
module shiftreg_seq
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] in_data,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic [1:0]       mode,
   input  logic             ser_in,
   input  logic             abort,
   output logic [WIDTH-1:0] out_q,
   output logic             ser_out,
   output logic             busy,
   output logic             done,
   output logic             zero
);
   import shiftreg_pkg::*;

   state_t           state_q;
   state_t           state_d;
   logic [AMT_W-1:0] cnt_q;
   logic [1:0]       mode_q;
   logic [WIDTH-1:0] step_val;
   logic             step_bit;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .value   (out_q),
      .mode    (mode_q),
      .ser_in  (ser_in),
      .nxt     (step_val),
      .out_bit (step_bit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!load && start) begin
               if (amount == '0) state_d = S_DONE;
               else              state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort)
               state_d = S_IDLE;
            else if (cnt_q == AMT_W'(1))
               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Mode and count are latched at start so live input
   // changes cannot disturb a running operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q   <= '0;
         ser_out <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= MODE_LSR;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (load) begin
                  out_q <= in_data;
               end else if (start && amount != '0) begin
                  mode_q <= mode;
                  cnt_q  <= amount;
               end
            end
            S_SHIFT: begin
               if (!abort) begin
                  out_q   <= step_val;
                  ser_out <= step_bit;
                  cnt_q   <= cnt_q - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);
   assign zero = (out_q == '0);

endmodule

// File: tb/tb_shiftreg_seq.sv
// tb_shiftreg_seq: vector table plus hand sequences
// for shiftreg_seq at WIDTH=8.
module tb_shiftreg_seq;
   import shiftreg_pkg::*;

   localparam int WIDTH = 8;
   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             start = 1'b0;
   logic [AMT_W-1:0] amount = '0;
   logic [1:0]       mode = 2'b00;
   logic             ser_in = 1'b0;
   logic             abort = 1'b0;
   logic [WIDTH-1:0] out_q;
   logic             ser_out;
   logic             busy;
   logic             done;
   logic             zero;

   always #5 clk = ~clk;

   shiftreg_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .in_data (in_data),
      .start   (start),
      .amount  (amount),
      .mode    (mode),
      .ser_in  (ser_in),
      .abort   (abort),
      .out_q   (out_q),
      .ser_out (ser_out),
      .busy    (busy),
      .done    (done),
      .zero    (zero)
   );

   typedef struct {
      logic             ld_en;
      logic [WIDTH-1:0] ld;
      logic [1:0]       md;
      logic [AMT_W-1:0] n;
      logic             si;
      logic [WIDTH-1:0] q;
      logic             so;
      logic             z;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             so;
      logic             z;
      int               lat;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[12];
   int   nvec = 0;
   int   nerr = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v);
      load    = 1'b1;
      in_data = v;
      tick();
      load    = 1'b0;
   endtask

   task automatic do_start(input logic [1:0] m,
                           input logic [AMT_W-1:0] n,
                           input logic si);
      mode   = m;
      amount = n;
      ser_in = si;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic push_exp(input logic [WIDTH-1:0] q,
                           input logic so,
                           input logic z,
                           input int lat);
      exp_t e;
      e.q   = q;
      e.so  = so;
      e.z   = z;
      e.lat = lat;
      sb.push_back(e);
   endtask

   // cyc0: edges already taken since (and including)
   // the start edge.
   task automatic wait_done(input string nm,
                            input int cyc0);
      exp_t e;
      int   cyc;
      e   = sb.pop_front();
      cyc = cyc0;
      while (!done && cyc < e.lat + 4) begin
         tick();
         cyc++;
      end
      chk({nm, " done"}, 32'(done), 32'(1));
      chk({nm, " lat"}, 32'(cyc), 32'(e.lat));
      chk({nm, " q"}, 32'(out_q), 32'(e.q));
      chk({nm, " ser"}, 32'(ser_out), 32'(e.so));
      chk({nm, " zero"}, 32'(zero), 32'(e.z));
      tick();
      chk({nm, " pulse"}, 32'(done), 32'(0));
   endtask

   initial begin
      tbl[0]  = '{1, 8'hB4, MODE_LSR, 4'd3,  0, 8'h16, 1, 0};
      tbl[1]  = '{1, 8'h90, MODE_ASR, 4'd2,  0, 8'hE4, 0, 0};
      tbl[2]  = '{1, 8'h81, MODE_ROR, 4'd9,  0, 8'hC0, 1, 0};
      tbl[3]  = '{1, 8'h81, MODE_LSL, 4'd1,  1, 8'h03, 1, 0};
      tbl[4]  = '{0, 8'h00, MODE_LSR, 4'd0,  0, 8'h03, 1, 0};
      tbl[5]  = '{1, 8'h01, MODE_LSL, 4'd7,  0, 8'h80, 0, 0};
      tbl[6]  = '{1, 8'h00, MODE_LSR, 4'd10, 1, 8'hFF, 1, 0};
      tbl[7]  = '{1, 8'h7F, MODE_ASR, 4'd15, 0, 8'h00, 0, 1};
      tbl[8]  = '{1, 8'hA5, MODE_ROR, 4'd4,  0, 8'h5A, 0, 0};
      tbl[9]  = '{1, 8'h80, MODE_LSL, 4'd1,  0, 8'h00, 1, 1};
      tbl[10] = '{1, 8'h80, MODE_ASR, 4'd3,  0, 8'hF0, 0, 0};
      tbl[11] = '{1, 8'h01, MODE_LSR, 4'd1,  0, 8'h00, 1, 1};

      // reset state, asynchronous before any edge
      #2;
      chk("rst q", 32'(out_q), 32'(0));
      chk("rst ser", 32'(ser_out), 32'(0));
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst done", 32'(done), 32'(0));
      chk("rst zero", 32'(zero), 32'(1));
      @(negedge clk);
      reset = 1'b1;
      tick();

      // table-driven full operations
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].ld_en) do_load(tbl[i].ld);
         push_exp(tbl[i].q, tbl[i].so, tbl[i].z,
                  int'(tbl[i].n) + 1);
         do_start(tbl[i].md, tbl[i].n, tbl[i].si);
         wait_done($sformatf("vec%0d", i), 1);
      end

      // LSR edge by edge
      do_load(8'hB4);
      do_start(MODE_LSR, 4'd3, 1'b0);
      chk("lsr busy0", 32'(busy), 32'(1));
      chk("lsr q0", 32'(out_q), 32'(8'hB4));
      tick();
      chk("lsr q1", 32'(out_q), 32'(8'h5A));
      tick();
      chk("lsr q2", 32'(out_q), 32'(8'h2D));
      chk("lsr busy2", 32'(busy), 32'(1));
      tick();
      chk("lsr q3", 32'(out_q), 32'(8'h16));
      chk("lsr busy3", 32'(busy), 32'(0));
      chk("lsr done3", 32'(done), 32'(1));
      tick();
      chk("lsr done4", 32'(done), 32'(0));

      // ROR 9 with live start/load/mode/amount noise
      do_load(8'h81);
      push_exp(8'hC0, 1'b1, 1'b0, 10);
      do_start(MODE_ROR, 4'd9, 1'b0);
      tick();
      tick();
      start   = 1'b1;
      load    = 1'b1;
      in_data = 8'h55;
      mode    = MODE_LSL;
      amount  = 4'd1;
      tick();
      tick();
      tick();
      start = 1'b0;
      load  = 1'b0;
      wait_done("ror9", 6);
      for (int k = 0; k < 3; k++) begin
         chk("ror9 idle", 32'(busy), 32'(0));
         tick();
      end
      chk("ror9 keep", 32'(out_q), 32'(8'hC0));

      // load wins over start in IDLE
      load    = 1'b1;
      start   = 1'b1;
      in_data = 8'h3C;
      mode    = MODE_LSR;
      amount  = 4'd2;
      tick();
      load  = 1'b0;
      start = 1'b0;
      chk("prio q", 32'(out_q), 32'(8'h3C));
      chk("prio busy", 32'(busy), 32'(0));
      tick();
      chk("prio done", 32'(done), 32'(0));
      chk("prio q2", 32'(out_q), 32'(8'h3C));

      // abort after 4 of 8 steps
      do_load(8'hFF);
      do_start(MODE_LSR, 4'd8, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      chk("abt q4", 32'(out_q), 32'(8'h0F));
      chk("abt busy4", 32'(busy), 32'(1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abt q", 32'(out_q), 32'(8'h0F));
      chk("abt busy", 32'(busy), 32'(0));
      chk("abt done", 32'(done), 32'(0));
      tick();
      chk("abt done2", 32'(done), 32'(0));
      // abort while idle does nothing
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abt idle q", 32'(out_q), 32'(8'h0F));
      chk("abt idle bsy", 32'(busy), 32'(0));

      // reset in the middle of a shift, between edges
      do_load(8'hAA);
      do_start(MODE_LSR, 4'd6, 1'b0);
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("mrst q", 32'(out_q), 32'(0));
      chk("mrst busy", 32'(busy), 32'(0));
      chk("mrst zero", 32'(zero), 32'(1));
      chk("mrst done", 32'(done), 32'(0));
      tick();
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("post rst done", 32'(done), 32'(0));
         chk("post rst busy", 32'(busy), 32'(0));
      end

      chk("sb empty", 32'(sb.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
